// File: rtl/b2s_pkg.sv
// b2s line protocol constants shared by transmitter and receiver.
// Nominal widths are in clocks; receiver defaults bound the accepted tolerance.
package b2s_pkg;
    localparam int NOM_START = 20;
    localparam int NOM_SHORT = 10;
    localparam int NOM_LONG  = 30;
    localparam int NOM_IDLE  = 1000;

    localparam int IDLE_MIN_DEF   = 200;
    localparam int START_MIN_DEF  = 15;
    localparam int START_MAX_DEF  = 25;
    localparam int BIT_THRESH_DEF = 20;
    localparam int LOW_MAX_DEF    = 40;
    localparam int HIGH_MAX_DEF   = 60;

    localparam int CNT_W = 10;

    typedef enum logic [2:0] {
        ST_WAIT_IDLE,
        ST_ARMED,
        ST_START_LOW,
        ST_START_HIGH,
        ST_BIT_LOW,
        ST_BIT_HIGH
    } b2s_state_e;
endpackage

// File: rtl/b2s_sync_edge.sv
// Synchronises the async b2s line and flags its edges.
// Latency: edge pulse 2 clk after the input changes. No backpressure.
// Flops reset to 1 so an idle-high line produces no edge after reset.
module b2s_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din_i,
    output logic lvl_o,
    output logic rise_o,
    output logic fall_o
);
    logic sync1_q, sync2_q, dly_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            dly_q   <= 1'b1;
        end else begin
            sync1_q <= din_i;
            sync2_q <= sync1_q;
            dly_q   <= sync2_q;
        end
    end

    assign lvl_o  = sync2_q;
    assign rise_o = sync2_q & ~dly_q;
    assign fall_o = ~sync2_q & dly_q;
endmodule

// File: rtl/b2s_receiver.sv
// Decodes b2s pulse-width frames into WIDTH-bit words.
// Latency: dout_valid 3 clk after the final bit's rising edge.
// No backpressure: dout/dout_valid/frame_err are single-cycle pulses.
module b2s_receiver
    import b2s_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int IDLE_MIN   = IDLE_MIN_DEF,
    parameter int START_MIN  = START_MIN_DEF,
    parameter int START_MAX  = START_MAX_DEF,
    parameter int BIT_THRESH = BIT_THRESH_DEF,
    parameter int LOW_MAX    = LOW_MAX_DEF,
    parameter int HIGH_MAX   = HIGH_MAX_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             b2s_din,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             frame_err
);
    localparam int BCW = $clog2(WIDTH + 1);

    // cnt_q holds (run length - 1) at an edge, so limits are pre-decremented.
    localparam logic [CNT_W-1:0] IDLE_LIM  = CNT_W'(IDLE_MIN - 1);
    localparam logic [CNT_W-1:0] SMIN_LIM  = CNT_W'(START_MIN - 1);
    localparam logic [CNT_W-1:0] SMAX_LIM  = CNT_W'(START_MAX - 1);
    localparam logic [CNT_W-1:0] BIT_LIM   = CNT_W'(BIT_THRESH - 1);
    localparam logic [CNT_W-1:0] LOW_LIM   = CNT_W'(LOW_MAX - 1);
    localparam logic [CNT_W-1:0] HIGH_LIM  = CNT_W'(HIGH_MAX - 1);
    localparam logic [BCW-1:0]   LAST_BIT  = BCW'(WIDTH - 1);

    logic lvl, rise, fall;

    b2s_sync_edge u_sync (
        .clk    (clk),
        .rst    (rst),
        .din_i  (b2s_din),
        .lvl_o  (lvl),
        .rise_o (rise),
        .fall_o (fall)
    );

    b2s_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BCW-1:0]   bcnt_q, bcnt_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             vld_q, vld_d;
    logic             err_q, err_d;
    logic             bit_val;
    logic [WIDTH-1:0] sr_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_WAIT_IDLE;
            cnt_q   <= '0;
            bcnt_q  <= '0;
            sr_q    <= '0;
            dout_q  <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bcnt_q  <= bcnt_d;
            sr_q    <= sr_d;
            dout_q  <= dout_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (rise || fall)
            cnt_d = '0;
        else if (cnt_q != '1)
            cnt_d = cnt_q + CNT_W'(1);
    end

    assign bit_val = (cnt_q < BIT_LIM);
    assign sr_next = {bit_val, sr_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        sr_d    = sr_q;
        dout_d  = dout_q;
        vld_d   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_WAIT_IDLE: begin
                // The count at a rising edge belongs to the preceding low run.
                if (lvl && !rise && cnt_q >= IDLE_LIM)
                    state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (fall) begin
                    state_d = ST_START_LOW;
                    bcnt_d  = '0;
                    sr_d    = '0;
                end
            end
            ST_START_LOW: begin
                if (rise) begin
                    if (cnt_q >= SMIN_LIM && cnt_q <= SMAX_LIM)
                        state_d = ST_START_HIGH;
                    else
                        err_d = 1'b1;
                end else if (cnt_q >= LOW_LIM) begin
                    err_d = 1'b1;
                end
            end
            ST_START_HIGH, ST_BIT_HIGH: begin
                if (fall)
                    state_d = ST_BIT_LOW;
                else if (cnt_q >= HIGH_LIM)
                    err_d = 1'b1;
            end
            ST_BIT_LOW: begin
                if (rise) begin
                    sr_d   = sr_next;
                    bcnt_d = bcnt_q + BCW'(1);
                    if (bcnt_q == LAST_BIT) begin
                        dout_d  = sr_next;
                        vld_d   = 1'b1;
                        sr_d    = '0;
                        bcnt_d  = '0;
                        state_d = ST_WAIT_IDLE;
                    end else begin
                        state_d = ST_BIT_HIGH;
                    end
                end else if (cnt_q >= LOW_LIM) begin
                    err_d = 1'b1;
                end
            end
            default: state_d = ST_WAIT_IDLE;
        endcase
        if (err_d) begin
            state_d = ST_WAIT_IDLE;
            sr_d    = '0;
            bcnt_d  = '0;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = vld_q;
    assign frame_err  = err_q;
endmodule

// File: tb/tb_b2s_receiver.sv
// Directed bench for b2s_receiver: table of frame vectors plus reset and power-up sequences.
module tb_b2s_receiver;
    import b2s_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        b2s_din;
    logic [31:0] dout;
    logic        dout_valid;
    logic        frame_err;

    b2s_receiver dut (
        .clk        (clk),
        .rst        (rst),
        .b2s_din    (b2s_din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int vld_total = 0;
    int err_total = 0;
    int both_total = 0;
    int last_vld_cyc = 0;
    int last_rise_cyc = 0;
    int n_chk = 0;
    int n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dout_valid) begin
            vld_total++;
            last_vld_cyc = cyc;
        end
        if (frame_err) err_total++;
        if (dout_valid && frame_err) both_total++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic hold(input logic lvl, input int n);
        b2s_din = lvl;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input int lo, input int hi, input bit last);
        hold(1'b0, lo);
        if (last) last_rise_cyc = cyc;
        hold(1'b1, hi);
    endtask

    task automatic send_frame(input int start_low, input logic [31:0] word,
                              input int idx, input int ovr_low, input int ovr_high);
        int lo, hi;
        hold(1'b0, start_low);
        hold(1'b1, NOM_START);
        for (int i = 0; i < 32; i++) begin
            lo = word[i] ? NOM_SHORT : NOM_LONG;
            if (i == idx && ovr_low != 0) lo = ovr_low;
            hi = (lo < 20) ? NOM_LONG : NOM_SHORT;
            if (i == idx && ovr_high != 0) hi = ovr_high;
            send_bit(lo, hi, i == 31);
        end
    endtask

    typedef struct {
        int          start_low;
        logic [31:0] word;
        int          idx;
        int          ovr_low;
        int          ovr_high;
        int          exp_vld;
        int          exp_err;
        logic [31:0] exp_dout;
    } vec_t;

    localparam int NV = 15;
    vec_t vt [NV];

    initial begin
        int v0, e0;
        vt[0]  = '{20, 32'hA5A5_0F0F, -1,  0,  0, 1, 0, 32'hA5A5_0F0F};
        vt[1]  = '{20, 32'h0000_0001, -1,  0,  0, 1, 0, 32'h0000_0001};
        vt[2]  = '{20, 32'hFFFF_FFFE, -1,  0,  0, 1, 0, 32'hFFFF_FFFE};
        vt[3]  = '{20, 32'h0000_0000,  7, 50,  0, 0, 1, 32'hFFFF_FFFE};
        vt[4]  = '{20, 32'h1234_5678, -1,  0,  0, 1, 0, 32'h1234_5678};
        vt[5]  = '{20, 32'h0000_0000,  3, 19,  0, 1, 0, 32'h0000_0008};
        vt[6]  = '{20, 32'hFFFF_FFFF,  5, 20,  0, 1, 0, 32'hFFFF_FFDF};
        vt[7]  = '{14, 32'h0000_0000, -1,  0,  0, 0, 1, 32'hFFFF_FFDF};
        vt[8]  = '{15, 32'h0BAD_F00D, -1,  0,  0, 1, 0, 32'h0BAD_F00D};
        vt[9]  = '{25, 32'hCAFE_BABE, -1,  0,  0, 1, 0, 32'hCAFE_BABE};
        vt[10] = '{26, 32'h0000_0000, -1,  0,  0, 0, 1, 32'hCAFE_BABE};
        vt[11] = '{20, 32'hFFFF_FFFF,  0, 40,  0, 1, 0, 32'hFFFF_FFFE};
        vt[12] = '{20, 32'hFFFF_FFFF,  0, 41,  0, 0, 1, 32'hFFFF_FFFE};
        vt[13] = '{20, 32'h0000_0000,  2,  0, 60, 1, 0, 32'h0000_0000};
        vt[14] = '{20, 32'hFFFF_FFFF,  2,  0, 61, 0, 1, 32'h0000_0000};

        // Line held low from time zero, under reset.
        rst = 1'b1;
        b2s_din = 1'b0;
        #2;
        chk("reset_dout", dout, 32'h0);
        chk("reset_vld", {31'b0, dout_valid}, 32'h0);
        chk("reset_err", {31'b0, frame_err}, 32'h0);
        @(posedge clk);
        #1;
        hold(1'b0, 3);
        rst = 1'b0;
        hold(1'b0, 500);

        // A frame after only 100 high clocks must be ignored.
        v0 = vld_total;
        e0 = err_total;
        hold(1'b1, 100);
        send_frame(20, 32'h1111_1111, -1, 0, 0);
        hold(1'b1, 300);
        chk("short_idle_vld", vld_total - v0, 32'd0);
        chk("short_idle_err", err_total - e0, 32'd0);
        chk("short_idle_dout", dout, 32'h0);

        // After a 300-clock high the next frame decodes.
        v0 = vld_total;
        send_frame(20, 32'h2222_2222, -1, 0, 0);
        hold(1'b1, NOM_IDLE);
        chk("long_idle_vld", vld_total - v0, 32'd1);
        chk("long_idle_dout", dout, 32'h2222_2222);

        for (int v = 0; v < NV; v++) begin
            v0 = vld_total;
            e0 = err_total;
            send_frame(vt[v].start_low, vt[v].word, vt[v].idx, vt[v].ovr_low, vt[v].ovr_high);
            hold(1'b1, NOM_IDLE);
            chk($sformatf("vec%0d_vld", v), vld_total - v0, vt[v].exp_vld);
            chk($sformatf("vec%0d_err", v), err_total - e0, vt[v].exp_err);
            chk($sformatf("vec%0d_dout", v), dout, vt[v].exp_dout);
            if (vt[v].exp_vld != 0)
                chk($sformatf("vec%0d_latency", v), last_vld_cyc - last_rise_cyc, 32'd3);
        end

        // Reset asserted during the low of bit 12 discards the frame silently.
        v0 = vld_total;
        e0 = err_total;
        hold(1'b0, NOM_START);
        hold(1'b1, NOM_START);
        for (int i = 0; i < 12; i++) send_bit(NOM_SHORT, NOM_LONG, 1'b0);
        hold(1'b0, 5);
        rst = 1'b1;
        hold(1'b1, 3);
        rst = 1'b0;
        chk("midrst_dout", dout, 32'h0);
        hold(1'b1, NOM_IDLE);
        chk("midrst_vld", vld_total - v0, 32'd0);
        chk("midrst_err", err_total - e0, 32'd0);
        v0 = vld_total;
        send_frame(20, 32'h5A5A_5A5A, -1, 0, 0);
        hold(1'b1, NOM_IDLE);
        chk("postrst_vld", vld_total - v0, 32'd1);
        chk("postrst_dout", dout, 32'h5A5A_5A5A);

        chk("vld_err_overlap", both_total, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/b2s_receiver.md
B2S_RECEIVER -- requirements
Module: b2s_receiver

Interface
REQ-001 Parameter WIDTH, default 32: number of data bits per frame.
REQ-002 Parameter IDLE_MIN, default 200: minimum continuous high, in clocks, that arms start detection.
REQ-003 Parameter START_MIN / START_MAX, default 15 / 25: accepted start-low width range, in clocks.
REQ-004 Parameter BIT_THRESH, default 20: a data-bit low width below this is logic 1; a width at or above it is logic 0.
REQ-005 Parameter LOW_MAX, default 40: any low width above this is an error.
REQ-006 Parameter HIGH_MAX, default 60: a mid-frame high width above this is an error.
REQ-007 Port clk, input, 1: single clock; must equal the transmitter clock.
REQ-008 Port rst, input, 1: reset, asynchronous and active-high.
REQ-009 Port b2s_din, input, 1: b2s serial line; asynchronous to clk, idles high.
REQ-010 Port dout, output, WIDTH: last correctly received word.
REQ-011 Port dout_valid, output, 1: one-clock pulse when dout is updated.
REQ-012 Port frame_err, output, 1: one-clock pulse when a frame is aborted.

Function
REQ-013 Line format SHALL be decoded as follows.
- Frame: idle high, then start (low ~20 clk, high ~20 clk), then WIDTH bits, LSB first.
- Bit 1: low ~10 clk, then high ~30 clk.
- Bit 0: low ~30 clk, then high ~10 clk.
- Inter-bit highs may exceed nominal by up to 3 clk.
REQ-014 b2s_din SHALL pass through a 2-FF synchronizer plus one delay FF for edge detection; all timing uses the synchronized signal.
REQ-015 The state machine SHALL have six states and these transitions.
- WAIT_IDLE -> ARMED after a high run of IDLE_MIN clocks; any low restarts the run count.
- ARMED -> START_LOW on a falling edge.
- START_LOW -> START_HIGH on a rising edge with low width in [START_MIN, START_MAX]; otherwise frame_err and WAIT_IDLE.
- START_HIGH -> BIT_LOW on a falling edge.
- BIT_LOW -> BIT_HIGH on a rising edge; the bit is classified using BIT_THRESH.
- BIT_HIGH -> BIT_LOW on a falling edge.
REQ-016 The width counter SHALL be 10 bits, saturating, cleared on each synchronized edge.
REQ-017 Each bit SHALL be shifted into a WIDTH-bit shift register at its rising edge, LSB first, and a bit counter (clog2(WIDTH+1) bits) SHALL increment.
REQ-018 On the rising edge that completes bit WIDTH-1, dout SHALL load the shift register and dout_valid SHALL pulse.
- Latency: 3 clk after b2s_din rises.
- Next state: WAIT_IDLE.
REQ-019 Error conditions SHALL pulse frame_err, discard the partial word, and return to WAIT_IDLE with dout unchanged. Error conditions:
- low width > LOW_MAX in any state;
- high width > HIGH_MAX in START_HIGH or BIT_HIGH.
REQ-020 dout SHALL hold its value between frames.
REQ-021 dout_valid and frame_err SHALL never be high in the same cycle.
REQ-022 A width exactly at a range limit SHALL be accepted: START_MIN, START_MAX, LOW_MAX, and HIGH_MAX are inclusive.
REQ-023 A line held low at power-up SHALL produce no output until IDLE_MIN high clocks have elapsed.

Reset
REQ-024 rst SHALL asynchronously set all of the following:
- state = WAIT_IDLE;
- counters = 0;
- shift register = 0;
- dout = 0, dout_valid = 0, frame_err = 0;
- synchronizer FFs = 1.
REQ-025 Reset asserted mid-frame SHALL discard the frame silently, with no frame_err.
REQ-026 After reset deassertion the block SHALL require a full IDLE_MIN high run before accepting a start.

Structure
REQ-027 Package b2s_pkg SHALL hold the protocol timing constants shared with the transmitter:
- nominal widths 20/10/30/1000;
- receiver defaults IDLE_MIN, START_MIN, START_MAX, BIT_THRESH, LOW_MAX, HIGH_MAX;
- state encodings.
REQ-028 Sub-module b2s_sync_edge SHALL implement the synchronizer and rise/fall pulse generation; everything else is in b2s_receiver.

Verification
REQ-029 Reset, then the transmitter sends 32'hA5A5_0F0F -> dout = 32'hA5A5_0F0F, exactly one dout_valid pulse, frame_err never high.
REQ-030 Two back-to-back frames with ~1000 clk idle, 32'h0000_0001 then 32'hFFFF_FFFE -> two dout_valid pulses with those values in order.
REQ-031 A 50-clk low injected at bit 7 -> one frame_err pulse and no dout_valid; a following clean frame 32'h1234_5678 is received correctly.
REQ-032 rst pulsed during bit 12 -> dout = 0 and no pulses; the next full frame after idle decodes correctly.
REQ-033 Line low from time 0, released, then a frame sent after 100 clk high -> frame ignored; a frame after a 300 clk high is decoded.
REQ-034 Handmade bit lows of 19 and 20 clk (all other bits nominal) -> bits decode as 1 and 0 respectively; a start low of 14 clk -> frame_err.
